// File: rtl/vga_ctrl.sv
// VGA 640x480@60 timing generator: h/v counters, sync decode, pixel requests
// issued PIX_LAT clocks early, and gated RGB. VGA_TEST_PATTERN_EN adds colour bars.
module vga_ctrl #(
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   H_VALID  = 640,
    parameter int   H_FRONT  = 16,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter int   V_VALID  = 480,
    parameter int   V_FRONT  = 10,
    parameter int   PIX_LAT  = 1,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_en,
`endif
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_req,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        frame_end
);

    localparam logic [9:0] H_LAST = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
    localparam logic [9:0] V_LAST = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
    localparam logic [9:0] HS_END = 10'(H_SYNC);
    localparam logic [9:0] VS_END = 10'(V_SYNC);
    localparam logic [9:0] HA_S   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] HA_E   = 10'(H_SYNC + H_BACK + H_VALID - 1);
    localparam logic [9:0] RQ_S   = 10'(H_SYNC + H_BACK - PIX_LAT);
    localparam logic [9:0] RQ_E   = 10'(H_SYNC + H_BACK + H_VALID - 1 - PIX_LAT);
    localparam logic [9:0] VA_S   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] VA_E   = 10'(V_SYNC + V_BACK + V_VALID - 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       v_act;
    logic       h_act;
    logic       h_req;

    // Line/frame position; line and frame wrap on the same clock.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= 10'd0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign hsync     = (h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
    assign vsync     = (v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
    assign v_act     = (v_cnt >= VA_S) && (v_cnt <= VA_E);
    assign h_act     = (h_cnt >= HA_S) && (h_cnt <= HA_E);
    assign h_req     = (h_cnt >= RQ_S) && (h_cnt <= RQ_E);
    assign rgb_valid = h_act && v_act;
    assign pix_req   = h_req && v_act;
    assign pix_x     = pix_req ? (h_cnt - RQ_S) : 10'h3FF;
    assign pix_y     = pix_req ? (v_cnt - VA_S) : 10'h3FF;
    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'd80;

    logic        test_q;
    logic [9:0]  bar;
    logic [15:0] bar_rgb;

    // Test enable is retimed so its effect starts on the following clock.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) test_q <= 1'b0;
        else            test_q <= test_en;
    end

    // Eight 80-pixel vertical colour bars across the active line.
    always_comb begin
        bar     = (h_cnt - HA_S) / BAR_W;
        bar_rgb = 16'h0000;
        case (bar)
            10'd0:   bar_rgb = 16'hFFFF;
            10'd1:   bar_rgb = 16'hFFE0;
            10'd2:   bar_rgb = 16'h07FF;
            10'd3:   bar_rgb = 16'h07E0;
            10'd4:   bar_rgb = 16'hF81F;
            10'd5:   bar_rgb = 16'hF800;
            10'd6:   bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase
    end

    assign rgb = rgb_valid ? (test_q ? bar_rgb : pix_data) : 16'h0000;
`else
    assign rgb = rgb_valid ? pix_data : 16'h0000;
`endif

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: a shrunk-timing instance for full-frame checks
// and a default-timing instance for the first active line.
module tb_vga_ctrl;

    localparam int HT = 658;
    localparam int VT = 15;
    localparam int FR = HT * VT;

    typedef struct {
        int          h;
        int          v;
        logic        hs;
        logic        vs;
        logic        req;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        val;
        logic [15:0] rgb;
        logic        fe;
    } vec_t;

    logic        clk;
    logic        rst_a, rst_b;
    logic        force_en;
    logic [15:0] pd_reg, pd_a, pd_b;
    logic [9:0]  px_a, py_a, px_b, py_b;
    logic        req_a, hs_a, vs_a, val_a, fe_a;
    logic        req_b, hs_b, vs_b, val_b, fe_b;
    logic [15:0] rgb_a, rgb_b;
    logic        te;
    int          hm, vm;
    int          total, bad;
    bit          done_b;
    vec_t        tbl[19];

    vga_ctrl #(
        .H_SYNC(8), .H_BACK(6), .H_VALID(640), .H_FRONT(4),
        .V_SYNC(2), .V_BACK(3), .V_VALID(8), .V_FRONT(2),
        .PIX_LAT(1), .SYNC_POL(1'b0)
    ) dut_a (
        .vga_clk(clk), .sys_rst_n(rst_a),
`ifdef VGA_TEST_PATTERN_EN
        .test_en(te),
`endif
        .pix_data(pd_a), .pix_x(px_a), .pix_y(py_a), .pix_req(req_a),
        .hsync(hs_a), .vsync(vs_a), .rgb_valid(val_a), .rgb(rgb_a),
        .frame_end(fe_a)
    );

    vga_ctrl dut_b (
        .vga_clk(clk), .sys_rst_n(rst_b),
`ifdef VGA_TEST_PATTERN_EN
        .test_en(1'b0),
`endif
        .pix_data(pd_b), .pix_x(px_b), .pix_y(py_b), .pix_req(req_b),
        .hsync(hs_b), .vsync(vs_b), .rgb_valid(val_b), .rgb(rgb_b),
        .frame_end(fe_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle pixel generator model: returns {row[5:0], col}.
    always @(posedge clk) pd_reg <= {py_a[5:0], px_a};
    assign pd_a = force_en ? 16'hFFFF : pd_reg;
    assign pd_b = 16'hA5A5;

    // Reference position of the shrunk instance.
    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            hm <= 0;
            vm <= 0;
        end else if (hm == HT - 1) begin
            hm <= 0;
            vm <= (vm == VT - 1) ? 0 : vm + 1;
        end else begin
            hm <= hm + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_hv(input int h, input int v, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * FR; i++) begin
            if (hm == h && vm == v) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: timeout waiting for h=%0d v=%0d", nm, h, v);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, " hsync"}, 32'(hs_a), 32'd0);
        chk({tag, " vsync"}, 32'(vs_a), 32'd0);
        chk({tag, " pix_req"}, 32'(req_a), 32'd0);
        chk({tag, " pix_x"}, 32'(px_a), 32'h3FF);
        chk({tag, " pix_y"}, 32'(py_a), 32'h3FF);
        chk({tag, " rgb_valid"}, 32'(val_a), 32'd0);
        chk({tag, " rgb"}, 32'(rgb_a), 32'd0);
        chk({tag, " frame_end"}, 32'(fe_a), 32'd0);
    endtask

    // Default-timing instance: sync widths and the first active line.
    initial begin
        done_b = 1'b0;
        #3;
        chk("b rst hsync", 32'(hs_b), 32'd0);
        chk("b rst pix_x", 32'(px_b), 32'h3FF);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        for (int n = 0; n <= 28784; n++) begin
            if (n == 95)    chk("b hsync@95", 32'(hs_b), 32'd0);
            if (n == 96)    chk("b hsync@96", 32'(hs_b), 32'd1);
            if (n == 1599)  chk("b vsync@1599", 32'(vs_b), 32'd0);
            if (n == 1600)  chk("b vsync@1600", 32'(vs_b), 32'd1);
            if (n == 28142) chk("b req@142", 32'(req_b), 32'd0);
            if (n == 28143) begin
                chk("b req@143", 32'(req_b), 32'd1);
                chk("b px@143", 32'(px_b), 32'd0);
                chk("b py@143", 32'(py_b), 32'd0);
                chk("b val@143", 32'(val_b), 32'd0);
                chk("b rgb@143", 32'(rgb_b), 32'd0);
            end
            if (n == 28144) begin
                chk("b val@144", 32'(val_b), 32'd1);
                chk("b rgb@144", 32'(rgb_b), 32'hA5A5);
            end
            if (n == 28782) chk("b px@782", 32'(px_b), 32'd639);
            if (n == 28783) begin
                chk("b req@783", 32'(req_b), 32'd0);
                chk("b val@783", 32'(val_b), 32'd1);
            end
            if (n == 28784) chk("b rgb@784", 32'(rgb_b), 32'd0);
            @(negedge clk);
        end
        done_b = 1'b1;
    end

    initial begin
        int c_hs, c_vs, c_fe, c_req, c_org, c_nv, c_in, c_out, n;
        total    = 0;
        bad      = 0;
        force_en = 1'b0;
        te       = 1'b0;
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        // h, v, hsync, vsync, req, px, py, valid, rgb, frame_end
        tbl[0]  = '{0,   0,  0, 0, 0, 10'h3FF, 10'h3FF, 0, 16'h0000, 0};
        tbl[1]  = '{7,   0,  0, 0, 0, 10'h3FF, 10'h3FF, 0, 16'h0000, 0};
        tbl[2]  = '{8,   0,  1, 0, 0, 10'h3FF, 10'h3FF, 0, 16'h0000, 0};
        tbl[3]  = '{657, 0,  1, 0, 0, 10'h3FF, 10'h3FF, 0, 16'h0000, 0};
        tbl[4]  = '{0,   1,  0, 0, 0, 10'h3FF, 10'h3FF, 0, 16'h0000, 0};
        tbl[5]  = '{0,   2,  0, 1, 0, 10'h3FF, 10'h3FF, 0, 16'h0000, 0};
        tbl[6]  = '{12,  5,  1, 1, 0, 10'h3FF, 10'h3FF, 0, 16'h0000, 0};
        tbl[7]  = '{13,  5,  1, 1, 1, 10'd0,   10'd0,   0, 16'h0000, 0};
        tbl[8]  = '{14,  5,  1, 1, 1, 10'd1,   10'd0,   1, 16'h0000, 0};
        tbl[9]  = '{15,  5,  1, 1, 1, 10'd2,   10'd0,   1, 16'h0001, 0};
        tbl[10] = '{652, 5,  1, 1, 1, 10'd639, 10'd0,   1, 16'h027E, 0};
        tbl[11] = '{653, 5,  1, 1, 0, 10'h3FF, 10'h3FF, 1, 16'h027F, 0};
        tbl[12] = '{654, 5,  1, 1, 0, 10'h3FF, 10'h3FF, 0, 16'h0000, 0};
        tbl[13] = '{13,  6,  1, 1, 1, 10'd0,   10'd1,   0, 16'h0000, 0};
        tbl[14] = '{14,  6,  1, 1, 1, 10'd1,   10'd1,   1, 16'h0400, 0};
        tbl[15] = '{653, 12, 1, 1, 0, 10'h3FF, 10'h3FF, 1, 16'h1E7F, 0};
        tbl[16] = '{13,  13, 1, 1, 0, 10'h3FF, 10'h3FF, 0, 16'h0000, 0};
        tbl[17] = '{656, 14, 1, 1, 0, 10'h3FF, 10'h3FF, 0, 16'h0000, 0};
        tbl[18] = '{657, 14, 1, 1, 0, 10'h3FF, 10'h3FF, 0, 16'h0000, 1};
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        chk_rst("por");
        rst_a = 1'b1;

        foreach (tbl[i]) begin
            wait_hv(tbl[i].h, tbl[i].v, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d hsync", i), 32'(hs_a), 32'(tbl[i].hs));
            chk($sformatf("vec%0d vsync", i), 32'(vs_a), 32'(tbl[i].vs));
            chk($sformatf("vec%0d req", i), 32'(req_a), 32'(tbl[i].req));
            chk($sformatf("vec%0d px", i), 32'(px_a), 32'(tbl[i].px));
            chk($sformatf("vec%0d py", i), 32'(py_a), 32'(tbl[i].py));
            chk($sformatf("vec%0d valid", i), 32'(val_a), 32'(tbl[i].val));
            chk($sformatf("vec%0d rgb", i), 32'(rgb_a), 32'(tbl[i].rgb));
            chk($sformatf("vec%0d fe", i), 32'(fe_a), 32'(tbl[i].fe));
        end

        // Two whole frames with pix_data stuck at FFFF.
        wait_hv(0, 0, "frame align");
        force_en = 1'b1;
        c_hs = 0; c_vs = 0; c_fe = 0; c_req = 0;
        c_org = 0; c_nv = 0; c_in = 0; c_out = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            if (!hs_a) c_hs++;
            if (!vs_a) c_vs++;
            if (fe_a) c_fe++;
            if (req_a) c_req++;
            if (req_a && px_a == 10'd0 && py_a == 10'd0) c_org++;
            if (!req_a && (px_a != 10'h3FF || py_a != 10'h3FF)) c_nv++;
            if (hm >= 14 && hm <= 653 && vm >= 5 && vm <= 12) begin
                if (rgb_a == 16'hFFFF) c_in++;
            end else if (rgb_a != 16'h0000) begin
                c_out++;
            end
            @(negedge clk);
        end
        force_en = 1'b0;
        chk("hsync low clocks", 32'(c_hs), 32'(2 * 8 * VT));
        chk("vsync low clocks", 32'(c_vs), 32'(2 * 2 * HT));
        chk("frame_end pulses", 32'(c_fe), 32'd2);
        chk("pix_req clocks", 32'(c_req), 32'(2 * 640 * 8));
        chk("origin requests", 32'(c_org), 32'd2);
        chk("idle coord not 3FF", 32'(c_nv), 32'd0);
        chk("active rgb FFFF", 32'(c_in), 32'(2 * 640 * 8));
        chk("blank rgb nonzero", 32'(c_out), 32'd0);

        // Reset in the middle of an active line.
        wait_hv(400, 10, "mid reset");
        rst_a = 1'b0;
        #1;
        chk_rst("mid0");
        repeat (3) @(negedge clk);
        chk_rst("mid3");
        rst_a = 1'b1;
        #1;
        chk("post hsync", 32'(hs_a), 32'd0);
        n = 0;
        while (!fe_a && n < FR + 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("post reset frame len", 32'(n), 32'(FR - 1));

`ifdef VGA_TEST_PATTERN_EN
        te = 1'b1;
        wait_hv(94, 7, "bar1");
        chk("bar1 rgb", 32'(rgb_a), 32'hFFE0);
        wait_hv(174, 7, "bar2");
        chk("bar2 rgb", 32'(rgb_a), 32'h07FF);
        chk("bar2 pix_x", 32'(px_a), 32'd161);
        wait_hv(574, 7, "bar7");
        chk("bar7 rgb", 32'(rgb_a), 32'h0000);
        wait_hv(14, 8, "bar0");
        chk("bar0 rgb", 32'(rgb_a), 32'hFFFF);
        te = 1'b0;
`endif

        for (int i = 0; i < 40000 && !done_b; i++) @(negedge clk);
        chk("default instance done", 32'(done_b), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
